// File: rtl/unified_memory_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter.
//   arb_state_t     : FSM state encoding (IDLE / ACCESS / RESP)
//   PORT_IF/PORT_DM : requester identifiers used by the grant registers
//   DATA_WIDTH      : width of all data paths
//   wait_cnt_width  : width of the wait-state counter, never less than 1 bit
package mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int DATA_WIDTH = 32;

  function automatic int wait_cnt_width(input int wait_states);
    return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/unified_memory_arbiter_wait_state_counter.sv
// Loadable down-counter that measures the memory latency of one access.
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset (count -> 0)
//   load_i       : load load_value_i (takes priority over dec_i)
//   load_value_i : value to load
//   dec_i        : decrement by one; saturates at zero
//   zero_o       : count is zero
module wait_state_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load_i) begin
      count_reg <= load_value_i;
    end else if (dec_i && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero_o = (count_reg == '0);

endmodule

// File: rtl/unified_memory_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF, read
// only) and the data stage (DM, load/store). One access at a time; each access
// is IDLE (sample) -> ACCESS (strobe + WAIT_STATES latency) -> RESP (ack).
//   clk, reset                 : clock and asynchronous active-low reset
//   if_req_i/if_addr_i         : fetch request and PC
//   if_ack_o/if_rdata_o        : fetch done pulse and held instruction
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : data request, store flag, address, store data
//   dm_ack_o/dm_rdata_o        : data done pulse and held load data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o : one-cycle memory strobe and its payload
//   mem_rdata_i                : memory read data, valid WAIT_STATES cycles after mem_en_o
//   busy_o                     : arbiter is not idle
module unified_memory_arbiter
  import mem_arb_defs::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_ack_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam int CNT_W = wait_cnt_width(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));

  arb_state_t state_reg;
  logic       grant_reg;
  logic       last_grant_reg;
  logic       we_reg;

  logic                  any_req;
  logic                  winner_next;
  logic                  store_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;

  assign any_req = if_req_i | dm_req_i;

  // On a tie the port that did not win last time goes first, so the two
  // requesters alternate and neither can be locked out.
  always_comb begin
    winner_next = PORT_IF;
    if (if_req_i && dm_req_i) begin
      winner_next = ~last_grant_reg;
    end else if (dm_req_i) begin
      winner_next = PORT_DM;
    end
  end

  assign store_next = (winner_next == PORT_DM) && dm_we_i;
  assign addr_next  = (winner_next == PORT_DM) ? dm_addr_i : if_addr_i;

  // The counter is loaded on the grant edge so it holds WAIT_STATES in the
  // first ACCESS cycle; with zero wait states the capture happens right there.
  assign cnt_load = (state_reg == ST_IDLE) && any_req;
  assign cnt_dec  = (state_reg == ST_ACCESS);

  wait_state_counter #(
    .WIDTH (CNT_W)
  ) u_wait_cnt (
    .clk          (clk),
    .reset        (reset),
    .load_i       (cnt_load),
    .load_value_i (CNT_W'(WAIT_STATES)),
    .dec_i        (cnt_dec),
    .zero_o       (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= PORT_IF;
      last_grant_reg <= PORT_IF;
      we_reg         <= 1'b0;
      if_ack_o       <= 1'b0;
      if_rdata_o     <= '0;
      dm_ack_o       <= 1'b0;
      dm_rdata_o     <= '0;
      mem_en_o       <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      busy_o         <= 1'b0;
    end else begin
      // Strobe and ack outputs are single-cycle pulses.
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            state_reg   <= ST_ACCESS;
            busy_o      <= 1'b1;
            grant_reg   <= winner_next;
            we_reg      <= store_next;
            mem_en_o    <= 1'b1;
            mem_we_o    <= store_next;
            mem_addr_o  <= addr_next & WORD_MASK;
            mem_wdata_o <= store_next ? dm_wdata_i : '0;
          end
        end

        ST_ACCESS: begin
          if (cnt_zero) begin
            state_reg <= ST_RESP;
            if (grant_reg == PORT_IF) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end else begin
              dm_ack_o <= 1'b1;
              // Stores leave the load-data holding register untouched.
              if (!we_reg) begin
                dm_rdata_o <= mem_rdata_i;
              end
            end
          end
        end

        ST_RESP: begin
          state_reg      <= ST_IDLE;
          busy_o         <= 1'b0;
          last_grant_reg <= grant_reg;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
